// File: rtl/ambi_core_p.sv
// ambi_core_p: parametrised accumulator CPU core.
// Fetches {opcode,operand} from an external imem at pc and accesses an external dmem
// at operand. A ready handshake lets memory ops stretch over several cycles.
// Optional feature: define AMBI_MUL_EN to turn opcode C into an unsigned multiply.
// When it is undefined, opcode C is a NOP and no multiplier is built.
module ambi_core_p #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   pc,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ADDR_W-1:0]   operand,
  input  logic [DATA_W-1:0]   ddatain,
  input  logic                dready,
  output logic [DATA_W-1:0]   accum,
  output logic                we,
  output logic                re,
  output logic                carry,
  output logic                halted
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_EXEC, S_WAIT, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        op;
  logic              is_rd, is_st, is_mem, retire;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W:0]   alu_res;

  // Result of a retiring instruction as {carry, accum}; flags untouched unless the op defines them.
  function automatic logic [DATA_W:0] alu(input logic [3:0] f, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] d, input logic c,
                                          input logic [ADDR_W-1:0] imm);
    logic [DATA_W:0] r;
`ifdef AMBI_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif
    r = {c, a};
    case (f)
      OP_LD:  r = {c, d};
      OP_ADD: r = {1'b0, a} + {1'b0, d};
      OP_SUB: r = {(d > a), a - d};
      OP_AND: r = {c, a & d};
      OP_OR:  r = {c, a | d};
      OP_XOR: r = {c, a ^ d};
      OP_LDI: r = {c, DATA_W'(imm)};
`ifdef AMBI_MUL_EN
      OP_MUL: begin
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, d};
        r = {|prod[2*DATA_W-1:DATA_W], prod[DATA_W-1:0]};
      end
`endif
      default: r = {c, a};
    endcase
    return r;
  endfunction

  // Decode: opcodes with any bit set above [3:0] are treated as NOP.
  always_comb begin
    op = ((opcode >> 4) == '0) ? opcode[3:0] : OP_NOP;
    is_rd = (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB) ||
            (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
`ifdef AMBI_MUL_EN
    if (op == OP_MUL) is_rd = 1'b1;
`endif
    is_st  = (op == OP_ST);
    is_mem = is_rd || is_st;
    retire = (state != S_HALT) && (op != OP_HALT) && (!is_mem || dready);
  end

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) state <= S_EXEC;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_EXEC: begin
        if (op == OP_HALT)          state_nxt = S_HALT;
        else if (is_mem && !dready) state_nxt = S_WAIT;
      end
      S_WAIT:  if (dready) state_nxt = S_EXEC;
      default: state_nxt = S_HALT;
    endcase
  end

  // Outputs: strobes stay up through WAIT because pc (and so opcode/operand) is held.
  always_comb begin
    re     = !rst && (state != S_HALT) && is_rd;
    we     = !rst && (state != S_HALT) && is_st;
    halted = (state == S_HALT);
  end

  // Next pc and retire result; jump conditions use the flags before this instruction.
  always_comb begin
    pc_nxt = pc + ADDR_W'(1);
    case (op)
      OP_JMP:  pc_nxt = operand;
      OP_JZ:   if (accum == '0) pc_nxt = operand;
      OP_JC:   if (carry) pc_nxt = operand;
      default: ;
    endcase
    alu_res = alu(op, accum, ddatain, carry, operand);
  end

  // Architectural state updates on retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      accum <= '0;
      carry <= 1'b0;
    end else if (retire) begin
      pc    <= pc_nxt;
      accum <= alu_res[DATA_W-1:0];
      carry <= alu_res[DATA_W];
    end
  end

endmodule
